// File: rtl/mips32_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_prog_loader
//  Description : Streams a program image into MIPS32 instruction memory.
//                Byte stream format: 4-byte word count N (MSB first), then
//                N 32-bit words (MSB byte first), then, when checksum support
//                is built in, a 4-byte sum (mod 2^32) of the data words.
//                The core is held halted until the image is fully written,
//                then released with a one-cycle start pulse.
//  Ports       : clk1      - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                in_data   - program byte stream
//                in_valid  - in_data valid
//                in_ready  - loader accepts a byte (HDR, DATA, CHK only)
//                mem_we    - instruction-memory write strobe (one per word)
//                mem_addr  - word address for mem_we
//                mem_wdata - word to write
//                core_halt - holds the core halted while high
//                start     - one-cycle pulse, core may fetch from PC=0
//                done      - load complete (sticky until reset)
//                err       - load failed (sticky until reset)
//  Config      : define MIPS32_LOADER_CHECKSUM_EN to add the CHK state and
//                the data-word accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips32_prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_halt,
    output logic              start,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WR    = 3'd3,
`ifdef MIPS32_LOADER_CHECKSUM_EN
        CHK   = 3'd4,
`endif
        START = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    // Largest legal word count; 33 bits so 2^ADDR_W is representable.
    localparam logic [32:0] c_max_words = 33'd1 << ADDR_W;

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         shift_q, shift_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                core_halt_q, core_halt_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                w_take;
    logic [31:0]         w_full;
    logic [ADDR_W:0]     w_next_cnt;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        w_take     = in_valid && in_ready_q;
        // Completed word if the current byte is the 4th of a group.
        w_full     = {shift_q, in_data};
        w_next_cnt = word_cnt_q + 1'b1;

        // Byte collection is shared by HDR, DATA and CHK; the 2-bit counter
        // wraps back to 0 after every 4th byte.
        if (w_take) begin
            shift_d    = w_full[23:0];
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        case (state_q)
            IDLE: state_d = HDR;
            HDR: begin
                if (w_take && byte_cnt_q == 2'd3) begin
                    if (w_full == 32'd0 || {1'b0, w_full} > c_max_words) begin
                        state_d = ERR;
                    end else begin
                        n_d     = w_full[ADDR_W:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (w_take && byte_cnt_q == 2'd3) begin
                    state_d     = WR;
                    mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                    mem_wdata_d = w_full;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + w_full;
`endif
                end
            end
            WR: begin
                word_cnt_d = w_next_cnt;
                if (w_next_cnt < n_q) begin
                    state_d = DATA;
                end else begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = START;
`endif
                end
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            CHK: begin
                if (w_take && byte_cnt_q == 2'd3) begin
                    state_d = (w_full == sum_q) ? START : ERR;
                end
            end
`endif
            START:   state_d = DONE;
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase

        // Outputs are registered, so decode them from the next state.
        in_ready_d  = (state_d == HDR) || (state_d == DATA)
`ifdef MIPS32_LOADER_CHECKSUM_EN
                      || (state_d == CHK)
`endif
                      ;
        mem_we_d    = (state_d == WR);
        core_halt_d = !((state_d == START) || (state_d == DONE));
        start_d     = (state_d == START);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            n_q         <= '0;
            word_cnt_q  <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_q       <= 32'd0;
`endif
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            core_halt_q <= 1'b1;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            core_halt_q <= core_halt_d;
            start_q     <= start_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_halt = core_halt_q;
    assign start     = start_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips32_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips32_prog_loader
//  Description : Self-checking bench for mips32_prog_loader (ADDR_W=4).
//                Drives program images with random valid gaps and checks
//                every memory write, its latency, and the final status
//                against a stream-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_prog_loader;

    localparam int AW = 4;
    localparam int MAX_N = 1 << AW;

    logic          clk1 = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_halt;
    logic          start;
    logic          done;
    logic          err;

    mips32_prog_loader #(.ADDR_W(AW)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_halt (core_halt),
        .start     (start),
        .done      (done),
        .err       (err)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [31:0] exp_words[$];
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc_cyc = -10;
    int wr_seen = 0;
    int last_wr_addr = -1;
    int start_cnt = 0;

    // Stream-level monitor: the k-th write must carry word k at address k,
    // arrive exactly one cycle after byte 4*(k+2) of the stream is accepted.
    always @(negedge clk1) begin
        cyc++;
        if (!rst_n) begin
            acc_cnt      = 0;
            wr_seen      = 0;
            start_cnt    = 0;
            last_wr_addr = -1;
            last_acc_cyc = -10;
        end else begin
            if (mem_we) begin
                check("wr_addr", mem_addr, wr_seen);
                if (wr_seen < exp_words.size())
                    check("wr_data", mem_wdata, exp_words[wr_seen]);
                else
                    check("wr_extra", 1, 0);
                check("wr_latency", cyc - last_acc_cyc, 1);
                check("wr_bytepos", acc_cnt, 4 * (wr_seen + 2));
                last_wr_addr = int'(mem_addr);
                wr_seen++;
            end
            if (start) begin
                start_cnt++;
                check("start_halt", core_halt, 0);
            end
            if (in_valid && in_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
        in_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) begin
            @(posedge clk1);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk1);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max, inout bit all_ok);
        bit ok;
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8], gap_max, ok);
            all_ok = all_ok && ok;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_in_ready"},  in_ready,  0);
        check({pfx, "_mem_we"},    mem_we,    0);
        check({pfx, "_mem_addr"},  mem_addr,  0);
        check({pfx, "_mem_wdata"}, mem_wdata, 0);
        check({pfx, "_core_halt"}, core_halt, 1);
        check({pfx, "_start"},     start,     0);
        check({pfx, "_done"},      done,      0);
        check({pfx, "_err"},       err,       0);
    endtask

    task automatic do_reset(input bit chk_vals);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk1);
        @(posedge clk1);
        #1;
        if (chk_vals) check_reset_values("rst");
        rst_n = 1'b1;
    endtask

    // Sends header hdr, then (if the header is legal) exp_words and the
    // optional checksum, and checks the final outcome.
    task automatic run_load(input string name, input logic [31:0] hdr, input int gap_max, input bit bad_ck);
        bit all_ok = 1'b1;
        bit hdr_bad;
        bit exp_err;
        bit finished = 1'b0;
        logic [31:0] sum = 32'd0;
        int n_exp;

        hdr_bad = (hdr == 32'd0) || (hdr > 32'(MAX_N));
        exp_err = hdr_bad;
        n_exp   = hdr_bad ? 0 : exp_words.size();

        send_word(hdr, gap_max, all_ok);
        if (!hdr_bad) begin
            foreach (exp_words[i]) begin
                send_word(exp_words[i], gap_max, all_ok);
                sum += exp_words[i];
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            send_word(bad_ck ? sum + 32'd1 : sum, gap_max, all_ok);
            exp_err = bad_ck;
`else
            if (bad_ck) sum = 32'd0;
`endif
        end
        check({name, "_accepted"}, all_ok, 1);

        for (int t = 0; t < 200; t++) begin
            @(negedge clk1);
            if (done || err) begin
                finished = 1'b1;
                break;
            end
        end
        check({name, "_finished"}, finished, 1);

        // Input after completion must be ignored.
        @(posedge clk1);
        #1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        repeat (6) @(posedge clk1);
        #1;
        in_valid = 1'b0;
        @(negedge clk1);

        check({name, "_done"},      done,      !exp_err);
        check({name, "_err"},       err,       exp_err);
        check({name, "_core_halt"}, core_halt, exp_err);
        check({name, "_in_ready"},  in_ready,  0);
        check({name, "_writes"},    wr_seen,   n_exp);
        check({name, "_starts"},    start_cnt, exp_err ? 0 : 1);
        if (n_exp > 0) check({name, "_last_addr"}, last_wr_addr, n_exp - 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok_mid;
        int n_rand;

        do_reset(1'b1);

        // Reference program
        exp_words = '{32'h2801000A, 32'h28020014, 32'h28030019, 32'h0CE77800, 32'h0CE77800,
                      32'h00222000, 32'h0CE77800, 32'h00832800, 32'hFC000000};
        run_load("prog9", 32'd9, 0, 1'b0);

        // Zero-length header
        do_reset(1'b0);
        exp_words = {};
        run_load("n0", 32'd0, 0, 1'b0);

        // One word too many for the memory
        do_reset(1'b0);
        run_load("n17", 32'd17, 0, 1'b0);

        // Full memory
        do_reset(1'b0);
        exp_words = {};
        for (int i = 0; i < MAX_N; i++) exp_words.push_back($urandom);
        run_load("n16", 32'd16, 0, 1'b0);

        // Random valid gaps
        do_reset(1'b0);
        exp_words = '{32'hAABBCCDD, 32'h11223344};
        run_load("gaps", 32'd2, 5, 1'b0);

        // Reset after 6 bytes of a load
        do_reset(1'b0);
        exp_words = '{32'h2801000A};
        ok_mid = 1'b1;
        send_word(32'd9, 0, ok_mid);
        begin
            bit ok1, ok2;
            send_byte(8'h28, 0, ok1);
            send_byte(8'h01, 0, ok2);
            ok_mid = ok_mid && ok1 && ok2;
        end
        check("mid_accepted", ok_mid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid");
        do_reset(1'b1);
        exp_words = '{32'hFC000000};
        run_load("after_rst", 32'd1, 0, 1'b0);

        // Random images
        for (int r = 0; r < 3; r++) begin
            do_reset(1'b0);
            exp_words = {};
            n_rand = $urandom_range(MAX_N, 1);
            for (int i = 0; i < n_rand; i++) exp_words.push_back($urandom);
            run_load("rand", 32'(n_rand), $urandom_range(3, 0), 1'b0);
        end

`ifdef MIPS32_LOADER_CHECKSUM_EN
        do_reset(1'b0);
        exp_words = '{32'h00000001, 32'h00000002};
        run_load("ck_good", 32'd2, 0, 1'b0);
        do_reset(1'b0);
        run_load("ck_bad", 32'd2, 0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not finish");
    end

endmodule
`default_nettype wire
